// File: rtl/enc_cw_buffer.sv
// ---------------------------------------------------------------------------
// enc_cw_buffer
//
// Double-buffered codeword assembly buffer for the RS encoder datapath.
// Message symbols arrive in IN_SYM-symbol beats into the write bank. Once the
// message is complete, the bank waits for the parity strobe, which latches the
// parity vector. Full banks are streamed out as OUT_SYM-symbol beats, message
// first and then parity. While one bank drains, the other can fill.
//
// Ports
//   clk        clock
//   rst_n      asynchronous active-low reset
//   clr        synchronous clear; overrides all other activity
//   in_valid   message beat valid
//   in_ready   message beat accepted when in_valid && in_ready
//   in_data    in_data[j] = message symbol beat*IN_SYM+j
//   par_valid  one-cycle parity-done strobe
//   par_data   parity vector; par_data[PAR_LEN-1] is transmitted first
//   out_valid  output beat valid
//   out_ready  output beat consumed when out_valid && out_ready
//   out_data   out_data[j] = codeword symbol beat*OUT_SYM+j
//   out_last   final beat of a codeword
//   par_err    one-cycle pulse after a par_valid that arrives outside WAIT_PAR
//
// Bank states
//   state       | meaning
//   ------------+-----------------------------------------------------
//   ST_EMPTY    | no data, free for the writer
//   ST_FILLING  | at least one message beat stored, message incomplete
//   ST_WAIT_PAR | message complete, waiting for the parity strobe
//   ST_FULL     | complete codeword, no beat sent yet
//   ST_DRAINING | complete codeword, at least one beat sent
// ---------------------------------------------------------------------------
module enc_cw_buffer #(
  parameter int SYM_W   = 8,
  parameter int IN_SYM  = 4,
  parameter int OUT_SYM = 8,
  parameter int MES_LEN = 32,
  parameter int PAR_LEN = 16
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             clr,
  input  logic                             in_valid,
  output logic                             in_ready,
  input  logic [IN_SYM-1:0][SYM_W-1:0]     in_data,
  input  logic                             par_valid,
  input  logic [PAR_LEN-1:0][SYM_W-1:0]    par_data,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic [OUT_SYM-1:0][SYM_W-1:0]    out_data,
  output logic                             out_last,
  output logic                             par_err
);

  localparam int CW_LEN    = MES_LEN + PAR_LEN;
  localparam int IN_BEATS  = MES_LEN / IN_SYM;
  localparam int OUT_BEATS = CW_LEN / OUT_SYM;
  localparam int IN_CW     = (IN_BEATS  > 1) ? $clog2(IN_BEATS)  : 1;
  localparam int OUT_CW    = (OUT_BEATS > 1) ? $clog2(OUT_BEATS) : 1;

  localparam logic [IN_CW-1:0]  IN_LAST  = IN_CW'(IN_BEATS - 1);
  localparam logic [OUT_CW-1:0] OUT_LAST = OUT_CW'(OUT_BEATS - 1);

  typedef enum logic [2:0] {
    ST_EMPTY    = 3'd0,
    ST_FILLING  = 3'd1,
    ST_WAIT_PAR = 3'd2,
    ST_FULL     = 3'd3,
    ST_DRAINING = 3'd4
  } bank_st_t;

  bank_st_t                        st [2];
  logic                            wp;
  logic                            rp;
  logic [IN_CW-1:0]                in_cnt;
  logic [OUT_CW-1:0]               out_cnt;
  logic [CW_LEN-1:0][SYM_W-1:0]    mem [2];

  logic in_fire;
  logic out_fire;
  logic par_load;

  // Handshake qualifiers are decoded from registered bank state only, so
  // neither ready nor valid has a combinational path from the other side.
  assign in_ready  = (st[wp] == ST_EMPTY) || (st[wp] == ST_FILLING);
  assign out_valid = (st[rp] == ST_FULL)  || (st[rp] == ST_DRAINING);
  assign out_last  = out_valid && (out_cnt == OUT_LAST);

  assign in_fire  = in_valid && in_ready;
  assign out_fire = out_valid && out_ready;
  assign par_load = par_valid && (st[wp] == ST_WAIT_PAR);

  always_comb begin
    out_data = '0;
    for (int b = 0; b < OUT_BEATS; b++) begin
      if (out_cnt == OUT_CW'(b)) begin
        for (int j = 0; j < OUT_SYM; j++) begin
          out_data[j] = mem[rp][b*OUT_SYM + j];
        end
      end
    end
  end

  // The write side only touches bank wp while it is EMPTY/FILLING/WAIT_PAR.
  // The read side only touches bank rp while it is FULL/DRAINING. The two
  // updates can therefore never target the same bank in one cycle, even when
  // wp == rp.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st[0]   <= ST_EMPTY;
      st[1]   <= ST_EMPTY;
      wp      <= 1'b0;
      rp      <= 1'b0;
      in_cnt  <= '0;
      out_cnt <= '0;
      par_err <= 1'b0;
      mem[0]  <= '0;
      mem[1]  <= '0;
    end else if (clr) begin
      st[0]   <= ST_EMPTY;
      st[1]   <= ST_EMPTY;
      wp      <= 1'b0;
      rp      <= 1'b0;
      in_cnt  <= '0;
      out_cnt <= '0;
      par_err <= 1'b0;
      mem[0]  <= '0;
      mem[1]  <= '0;
    end else begin
      par_err <= par_valid && (st[wp] != ST_WAIT_PAR);

      if (in_fire) begin
        for (int b = 0; b < IN_BEATS; b++) begin
          if (in_cnt == IN_CW'(b)) begin
            for (int j = 0; j < IN_SYM; j++) begin
              mem[wp][b*IN_SYM + j] <= in_data[j];
            end
          end
        end
        if (in_cnt == IN_LAST) begin
          st[wp] <= ST_WAIT_PAR;
          in_cnt <= '0;
        end else begin
          st[wp] <= ST_FILLING;
          in_cnt <= in_cnt + IN_CW'(1);
        end
      end else if (par_load) begin
        // Highest-degree parity symbol lands first in the codeword.
        for (int p = 0; p < PAR_LEN; p++) begin
          mem[wp][MES_LEN + p] <= par_data[PAR_LEN-1-p];
        end
        st[wp] <= ST_FULL;
        wp     <= ~wp;
      end

      if (out_fire) begin
        if (out_cnt == OUT_LAST) begin
          st[rp]  <= ST_EMPTY;
          rp      <= ~rp;
          out_cnt <= '0;
        end else begin
          st[rp]  <= ST_DRAINING;
          out_cnt <= out_cnt + OUT_CW'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_enc_cw_buffer.sv
// ---------------------------------------------------------------------------
// tb_enc_cw_buffer
//
// Directed bench for enc_cw_buffer. Stimulus is driven and outputs are sampled
// on the falling clock edge. Codeword n uses base value c. Message symbol i is
// c+i. Parity par_data[k] is c+0x80+k. The expected output symbol at codeword
// position p therefore is c+p for the message, and c+0x80+(CW_LEN-1-p) for
// the parity.
// ---------------------------------------------------------------------------
module tb_enc_cw_buffer;

  localparam int SYM_W     = 8;
  localparam int IN_SYM    = 4;
  localparam int OUT_SYM   = 8;
  localparam int MES_LEN   = 32;
  localparam int PAR_LEN   = 16;
  localparam int CW_LEN    = 48;
  localparam int IN_BEATS  = 8;
  localparam int OUT_BEATS = 6;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic clr = 1'b0;
  logic in_valid = 1'b0;
  logic par_valid = 1'b0;
  logic out_ready = 1'b0;
  logic in_ready, out_valid, out_last, par_err;
  logic [IN_SYM-1:0][SYM_W-1:0]  in_data  = '0;
  logic [PAR_LEN-1:0][SYM_W-1:0] par_data = '0;
  logic [OUT_SYM-1:0][SYM_W-1:0] out_data;

  int n_checks = 0;
  int n_fail   = 0;

  enc_cw_buffer #(
    .SYM_W(SYM_W), .IN_SYM(IN_SYM), .OUT_SYM(OUT_SYM),
    .MES_LEN(MES_LEN), .PAR_LEN(PAR_LEN)
  ) dut (
    .clk(clk), .rst_n(rst_n), .clr(clr),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .par_valid(par_valid), .par_data(par_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_last(out_last), .par_err(par_err)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] exp_sym(input logic [7:0] c, input int pos);
    if (pos < MES_LEN) return c + 8'(pos);
    return c + 8'h80 + 8'(CW_LEN - 1 - pos);
  endfunction

  // Send message beats first..last of codeword c; starts and ends on a negedge.
  task automatic send_msg(input logic [7:0] c, input int first, input int last);
    int w;
    for (int b = first; b <= last; b++) begin
      in_valid = 1'b1;
      for (int j = 0; j < IN_SYM; j++) in_data[j] = c + 8'(b*IN_SYM + j);
      w = 0;
      while (!in_ready && w < 300) begin
        // A stalled writer must always mean a codeword is waiting to drain.
        n_checks++;
        if (out_valid !== 1'b1) begin
          n_fail++;
          $display("FAIL in_stall_reason: in_ready low with out_valid=%b, required 1", out_valid);
        end
        @(negedge clk);
        w++;
      end
      n_checks++;
      if (in_ready !== 1'b1) begin
        n_fail++;
        $display("FAIL in_accept_timeout: beat %0d of cw %h in_ready=%b, required 1", b, c, in_ready);
      end
      @(negedge clk);
    end
    in_valid = 1'b0;
  endtask

  task automatic send_par(input logic [7:0] c);
    par_valid = 1'b1;
    for (int k = 0; k < PAR_LEN; k++) par_data[k] = c + 8'h80 + 8'(k);
    @(negedge clk);
    par_valid = 1'b0;
  endtask

  // Collect nb beats of codeword c. If rnd is set, out_ready toggles randomly
  // and stalled beats are checked for stability.
  task automatic collect(input logic [7:0] c, input int nb, input bit rnd, input string tag);
    logic [OUT_SYM-1:0][SYM_W-1:0] held;
    bit stalled;
    bit got;
    int w;
    for (int b = 0; b < nb; b++) begin
      got = 1'b0;
      w = 0;
      while (!got) begin
        out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
        stalled = out_valid && !out_ready;
        held = out_data;
        if (out_valid && out_ready) begin
          got = 1'b1;
          for (int j = 0; j < OUT_SYM; j++) begin
            n_checks++;
            if (out_data[j] !== exp_sym(c, b*OUT_SYM + j)) begin
              n_fail++;
              $display("FAIL %s_data: beat %0d sym %0d got %h, required %h",
                       tag, b, j, out_data[j], exp_sym(c, b*OUT_SYM + j));
            end
          end
          n_checks++;
          if (out_last !== 1'(b == OUT_BEATS - 1)) begin
            n_fail++;
            $display("FAIL %s_last: beat %0d out_last=%b, required %b",
                     tag, b, out_last, (b == OUT_BEATS - 1));
          end
        end
        @(negedge clk);
        if (stalled) begin
          n_checks++;
          if (out_valid !== 1'b1 || out_data !== held) begin
            n_fail++;
            $display("FAIL %s_stall_hold: beat %0d valid=%b data=%h, required valid=1 data=%h",
                     tag, b, out_valid, out_data, held);
          end
        end
        if (!got) begin
          w++;
          if (w > 300) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s_out_timeout: beat %0d out_valid=%b, required 1", tag, b, out_valid);
            out_ready = 1'b0;
            return;
          end
        end
      end
    end
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    n_checks++;
    if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b, required 1", in_ready); end
    n_checks++;
    if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b, required 0", out_valid); end
    n_checks++;
    if (out_last !== 1'b0) begin n_fail++; $display("FAIL reset_out_last: got %b, required 0", out_last); end
    n_checks++;
    if (out_data !== '0) begin n_fail++; $display("FAIL reset_out_data: got %h, required 0", out_data); end
    n_checks++;
    if (par_err !== 1'b0) begin n_fail++; $display("FAIL reset_par_err: got %b, required 0", par_err); end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_basic();
    send_msg(8'h00, 0, IN_BEATS - 1);
    n_checks++;
    if (in_ready !== 1'b0) begin n_fail++; $display("FAIL basic_wait_par_ready: got %b, required 0", in_ready); end
    n_checks++;
    if (out_valid !== 1'b0) begin n_fail++; $display("FAIL basic_valid_before_par: got %b, required 0", out_valid); end
    send_par(8'h00);
    n_checks++;
    if (out_valid !== 1'b1) begin n_fail++; $display("FAIL basic_valid_after_par: got %b, required 1", out_valid); end
    n_checks++;
    if (par_err !== 1'b0) begin n_fail++; $display("FAIL basic_par_err: got %b, required 0", par_err); end
    collect(8'h00, OUT_BEATS, 1'b0, "basic");
    n_checks++;
    if (out_valid !== 1'b0) begin n_fail++; $display("FAIL basic_idle_after: out_valid=%b, required 0", out_valid); end
  endtask

  task automatic test_back_to_back();
    fork
      begin
        send_msg(8'h10, 0, IN_BEATS - 1); send_par(8'h10);
        send_msg(8'h40, 0, IN_BEATS - 1); send_par(8'h40);
        send_msg(8'h70, 0, IN_BEATS - 1); send_par(8'h70);
      end
      begin
        collect(8'h10, OUT_BEATS, 1'b0, "b2b_a");
        collect(8'h40, OUT_BEATS, 1'b0, "b2b_b");
        collect(8'h70, OUT_BEATS, 1'b0, "b2b_c");
      end
    join
    @(negedge clk);
    n_checks++;
    if (out_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_idle_after: out_valid=%b, required 0", out_valid); end
  endtask

  task automatic test_stall();
    send_msg(8'h20, 0, IN_BEATS - 1);
    send_par(8'h20);
    collect(8'h20, OUT_BEATS, 1'b1, "stall");
    @(negedge clk);
    n_checks++;
    if (out_valid !== 1'b0) begin n_fail++; $display("FAIL stall_extra_beat: out_valid=%b, required 0", out_valid); end
  endtask

  task automatic test_par_err();
    send_msg(8'h30, 0, 2);
    par_valid = 1'b1;
    for (int k = 0; k < PAR_LEN; k++) par_data[k] = 8'hEE;
    @(negedge clk);
    par_valid = 1'b0;
    n_checks++;
    if (par_err !== 1'b1) begin n_fail++; $display("FAIL par_err_pulse: got %b, required 1", par_err); end
    @(negedge clk);
    n_checks++;
    if (par_err !== 1'b0) begin n_fail++; $display("FAIL par_err_single: got %b, required 0", par_err); end
    n_checks++;
    if (out_valid !== 1'b0) begin n_fail++; $display("FAIL par_err_no_cw: out_valid=%b, required 0", out_valid); end
    n_checks++;
    if (in_ready !== 1'b1) begin n_fail++; $display("FAIL par_err_still_filling: in_ready=%b, required 1", in_ready); end
    send_msg(8'h30, 3, IN_BEATS - 1);
    send_par(8'h30);
    n_checks++;
    if (par_err !== 1'b0) begin n_fail++; $display("FAIL par_err_good_par: got %b, required 0", par_err); end
    collect(8'h30, OUT_BEATS, 1'b0, "par_err");
  endtask

  task automatic test_clr();
    send_msg(8'h50, 0, IN_BEATS - 1);
    send_par(8'h50);
    send_msg(8'hA0, 0, 1);
    collect(8'h50, 3, 1'b0, "clr_pre");
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    n_checks++;
    if (out_valid !== 1'b0) begin n_fail++; $display("FAIL clr_out_valid: got %b, required 0", out_valid); end
    n_checks++;
    if (in_ready !== 1'b1) begin n_fail++; $display("FAIL clr_in_ready: got %b, required 1", in_ready); end
    n_checks++;
    if (out_last !== 1'b0) begin n_fail++; $display("FAIL clr_out_last: got %b, required 0", out_last); end
    n_checks++;
    if (out_data !== '0) begin n_fail++; $display("FAIL clr_out_data: got %h, required 0", out_data); end
    send_msg(8'h60, 0, IN_BEATS - 1);
    send_par(8'h60);
    collect(8'h60, OUT_BEATS, 1'b0, "clr_post");
  endtask

  task automatic test_async_reset();
    send_msg(8'h70, 0, IN_BEATS - 1);
    send_par(8'h70);
    send_msg(8'h78, 0, 2);
    n_checks++;
    if (out_valid !== 1'b1) begin n_fail++; $display("FAIL arst_pending: out_valid=%b, required 1", out_valid); end
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if (out_valid !== 1'b0) begin n_fail++; $display("FAIL arst_out_valid: got %b, required 0", out_valid); end
    n_checks++;
    if (in_ready !== 1'b1) begin n_fail++; $display("FAIL arst_in_ready: got %b, required 1", in_ready); end
    n_checks++;
    if (out_data !== '0) begin n_fail++; $display("FAIL arst_out_data: got %h, required 0", out_data); end
    n_checks++;
    if (out_last !== 1'b0) begin n_fail++; $display("FAIL arst_out_last: got %b, required 0", out_last); end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    send_msg(8'h90, 0, IN_BEATS - 1);
    send_par(8'h90);
    collect(8'h90, OUT_BEATS, 1'b0, "arst_post");
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_basic();
    test_back_to_back();
    test_stall();
    test_par_err();
    test_clr();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/enc_cw_buffer.md
# enc_cw_buffer

Parametrised, double-buffered codeword assembly buffer for the RS encoder datapath. It collects message symbols from the generator in IN_SYM-symbol beats and latches the parity vector when the parity processor finishes. It then streams the complete codeword (message first, then parity) to the downstream interface in OUT_SYM-symbol beats under valid/ready backpressure. Two banks let one codeword drain while the next fills. Upstream flow control comes from in_ready rather than an external stall.

## Interface
- SYM_W, 8, symbol width in bits (EGF_DIM)
- IN_SYM, 4, symbols per input beat; MES_LEN % IN_SYM == 0
- OUT_SYM, 8, symbols per output beat; (MES_LEN+PAR_LEN) % OUT_SYM == 0
- MES_LEN, 32, message symbols per codeword
- PAR_LEN, 16, parity symbols per codeword
- Derived: CW_LEN = MES_LEN+PAR_LEN; IN_BEATS = MES_LEN/IN_SYM; OUT_BEATS = CW_LEN/OUT_SYM
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- clr  in  1  synchronous clear; highest priority
- in_valid  in  1  message beat valid
- in_ready  out  1  message beat accepted when in_valid && in_ready
- in_data  in  [IN_SYM][SYM_W]  in_data[j] = message symbol beat*IN_SYM+j
- par_valid  in  1  one-cycle parity-done strobe
- par_data  in  [PAR_LEN][SYM_W]  parity vector
- out_valid  out  1  output beat valid
- out_ready  in  1  output beat consumed when out_valid && out_ready
- out_data  out  [OUT_SYM][SYM_W]  out_data[j] = codeword symbol beat*OUT_SYM+j
- out_last  out  1  high with the final beat (beat OUT_BEATS-1) of a codeword
- par_err  out  1  one-cycle pulse: par_valid received while the write bank is not in WAIT_PAR

## Operation
- Two banks of CW_LEN symbol registers. Each bank has a state EMPTY, FILLING, WAIT_PAR, FULL, DRAINING. Write bank pointer wp, read bank pointer rp (1 bit each).
- Write bank transitions:
  - EMPTY→FILLING on the first accepted beat.
  - After beat IN_BEATS-1 is accepted → WAIT_PAR. This includes IN_BEATS==1, where EMPTY goes straight to WAIT_PAR.
  - WAIT_PAR→FULL on par_valid; wp toggles.
- in_ready = state[wp] ∈ {EMPTY, FILLING}, decoded from registers only.
- Input beat counter 0..IN_BEATS-1 wraps to 0 when the write bank enters WAIT_PAR.
- Codeword mapping: positions 0..MES_LEN-1 hold message symbols in arrival order. Position MES_LEN+p holds par_data[PAR_LEN-1-p], so the highest-degree parity symbol is transmitted first.
- par_valid outside WAIT_PAR: ignored (no bank write), par_err pulses next cycle.
- Read side:
  - out_valid = state[rp] ∈ {FULL, DRAINING}.
  - out_data is muxed from bank rp by the output beat counter.
  - First handshake moves FULL→DRAINING.
  - Handshake on beat OUT_BEATS-1 moves the bank to EMPTY, toggles rp, and resets the counter.
- out_valid is not withdrawn, and out_data does not change, while out_ready is low.
- Simultaneous events:
  - A drain-complete on one bank and a fill or parity load on the other proceed independently in the same cycle.
  - A bank freed at edge t is offered to the writer only from cycle t+1; no same-cycle reuse.
- Both banks busy (FULL/DRAINING/WAIT_PAR on wp): in_ready low. Beats offered are held by upstream and not lost.
- clr or rst_n: all banks EMPTY, wp = rp = 0, counters 0, bank contents 0. Any partial codeword is discarded. clr mid-drain truncates output with no out_last.

## Timing
- Reset values: in_ready=1, out_valid=0, out_last=0, out_data=0, par_err=0.
- Parity strobe accepted at edge t (bank in WAIT_PAR): out_valid high in cycle t+1 if rp points to that bank.
- Earliest parity acceptance is the cycle after the last message beat's edge.
- Steady state with out_ready=1 and in_valid=1: output runs at 1 beat/cycle. Input stalls only when both banks are occupied.
- out_last = out_valid && (out beat counter == OUT_BEATS-1). Combinational from registers.
- par_err registered: pulse in the cycle after the offending par_valid.

## Test plan
- Reset release, then 8 in beats carrying symbols 0x00..0x1F, then par_valid with par_data[k]=0x80+k → 6 output beats:
  - Beats 0–3 carry 0x00..0x1F in order.
  - Beat 4 carries 0x8F..0x88; beat 5 carries 0x87..0x80.
  - out_last only on beat 5.
- Continuous back-to-back codewords A, B, C with out_ready=1 → no symbol loss or reorder. in_ready drops only while both banks hold codewords.
- out_ready toggled randomly 50% during a drain → out_data stable while stalled; exactly 6 handshakes per codeword.
- par_valid pulsed during FILLING (after 3 beats) → par_err pulses once. Bank contents unchanged; a later valid parity completes the codeword correctly.
- clr asserted after out beat 2 of codeword A while B is FILLING → next cycle out_valid=0 and in_ready=1. A fresh codeword then outputs correctly from bank 0.
- rst_n asserted asynchronously mid-fill → outputs take reset values immediately; the next codeword starts at input beat 0.
